// File: rtl/rv64_inst_fetch.sv
// Instruction fetch front end: walks the PC through byte-wide memory, assembles
// little-endian 32-bit words and presents them with a valid/ready handshake.
module rv64_inst_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BASE   = 64'h0000_0000_8000_0000,
  parameter int          MEM_ADDR_W = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rd_data,
  output logic [31:0]           inst,
  output logic [63:0]           inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_count
);

  // state   | meaning
  // S_FETCH | issuing byte reads / collecting returned bytes
  // S_HOLD  | word presented, waiting for consumer
  // S_FAULT | PC not fetchable, waiting for redirect
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} state_e;

  state_e                state_q, state_d;
  logic [63:0]           pc_q, pc_d;
  logic [2:0]            issue_q, issue_d;
  logic [1:0]            cap_q, cap_d;
  logic                  pend_q, pend_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           inst_q, inst_d;
  logic [63:0]           inst_pc_q, inst_pc_d;
  logic                  valid_q, valid_d;
  logic                  rd_en_q, rd_en_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic                  fault_q, fault_d;
  logic [31:0]           count_q, count_d;
  logic                  handshake;
  logic                  enter;

  function automatic logic fetchable(input logic [63:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= MEM_BASE) &&
           (((pc - MEM_BASE) >> MEM_ADDR_W) == 64'd0);
  endfunction

  assign handshake = valid_q & inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    pend_d    = rd_en_q;
    buf_d     = buf_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    fault_d   = fault_q;
    count_d   = count_q;
    enter     = 1'b0;

    if (handshake) count_d = count_q + 32'd1;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      fault_d = 1'b0;
      enter   = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          // issue_q==0 only right after reset: PC not yet checked
          if (issue_q == 3'd0) begin
            enter = 1'b1;
          end else begin
            if (!issue_q[2]) begin
              rd_en_d = 1'b1;
              addr_d  = addr_q + MEM_ADDR_W'(1);
              issue_d = issue_q + 3'd1;
            end
            if (pend_q) begin
              buf_d[{cap_q, 3'b000} +: 8] = mem_rd_data;
              cap_d = cap_q + 2'd1;
              if (cap_q == 2'd3) begin
                inst_d    = {mem_rd_data, buf_q[23:0]};
                inst_pc_d = pc_q;
                valid_d   = 1'b1;
                state_d   = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (handshake) begin
            valid_d = 1'b0;
            pc_d    = pc_q + 64'd4;
            enter   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Byte 0 of the new PC is issued on the same edge FETCH is entered.
    if (enter) begin
      pend_d  = 1'b0;
      cap_d   = 2'd0;
      if (fetchable(pc_d)) begin
        state_d = S_FETCH;
        rd_en_d = 1'b1;
        addr_d  = MEM_ADDR_W'(pc_d - MEM_BASE);
        issue_d = 3'd1;
      end else begin
        state_d = S_FAULT;
        issue_d = 3'd0;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      issue_q   <= 3'd0;
      cap_q     <= 2'd0;
      pend_q    <= 1'b0;
      buf_q     <= 32'd0;
      inst_q    <= 32'd0;
      inst_pc_q <= 64'd0;
      valid_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      fault_q   <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      pend_q    <= pend_d;
      buf_q     <= buf_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = addr_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule
